// File: rtl/sig_pkg.sv
// Shared lamp-code, fault-code and monitor-state encodings for the signal controller and monitor.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sig_pkg;

    localparam logic [1:0] RED      = 2'd0;
    localparam logic [1:0] YELLOW   = 2'd1;
    localparam logic [1:0] GREEN    = 2'd2;
    localparam logic [1:0] DARK     = 2'd3;
    // Code 3 on a controller output is never a valid colour request.
    localparam logic [1:0] CODE_BAD = 2'd3;

    localparam logic [2:0] FLT_NONE         = 3'd0;
    localparam logic [2:0] FLT_ILLEGAL      = 3'd1;
    localparam logic [2:0] FLT_CONFLICT     = 3'd2;
    localparam logic [2:0] FLT_BAD_TRANS    = 3'd3;
    localparam logic [2:0] FLT_SHORT_YELLOW = 3'd4;
    localparam logic [2:0] FLT_LONG_YELLOW  = 3'd5;
    localparam logic [2:0] FLT_SHORT_ALLRED = 3'd6;

    typedef enum logic [1:0] {
        MON_INIT  = 2'd0,
        MON_RUN   = 2'd1,
        MON_FAULT = 2'd2
    } mon_state_t;

endpackage

// File: rtl/sig_road_tracker.sv
// Per-road history: previous code, yellow timer, transition/yellow-timing flags, to-GREEN pulse.
// Latency: flags are combinational on the current code against registered history.
// Backpressure: none; samples every cycle.
module sig_road_tracker
    import sig_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int MIN_YELLOW = 3,
    parameter int MAX_YELLOW = 8
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [1:0] code,
    output logic       bad_trans,
    output logic       short_yellow,
    output logic       long_yellow,
    output logic       to_green
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       prev_code;
    logic [CNT_W-1:0] yel_cnt;
    logic             legal_step;

    // yel_cnt counts the YELLOW samples strictly before the current one.
    always_comb begin
        legal_step   = (prev_code == GREEN  && code == YELLOW) ||
                       (prev_code == YELLOW && code == RED)    ||
                       (prev_code == RED    && code == GREEN);
        bad_trans    = (code != prev_code) && !legal_step;
        short_yellow = (prev_code == YELLOW) && (code == RED) &&
                       (yel_cnt < CNT_W'(MIN_YELLOW));
        long_yellow  = (code == YELLOW) && (yel_cnt >= CNT_W'(MAX_YELLOW));
        to_green     = (prev_code == RED) && (code == GREEN);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            prev_code <= RED;
            yel_cnt   <= '0;
        end else begin
            prev_code <= code;
            if (code != YELLOW)
                yel_cnt <= '0;
            else if (yel_cnt != CNT_MAX)
                yel_cnt <= yel_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sig_monitor.sv
// Conflict/sequence monitor: passes lamp codes through, latches first fault and flashes RED/DARK.
// Latency: 1 cycle input-to-lamp; fault visible the cycle after the offending sample.
// Backpressure: none; inputs are sampled every cycle and ignored while faulted.
module sig_monitor
    import sig_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int MIN_YELLOW = 3,
    parameter int MAX_YELLOW = 8,
    parameter int MIN_ALLRED = 2,
    parameter int FLASH_DIV  = 4
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [1:0] hwy,
    input  logic [1:0] cntry,
    output logic [1:0] hwy_lamp,
    output logic [1:0] cntry_lamp,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             h_bad, h_short, h_long, h_green;
    logic             c_bad, c_short, c_long, c_green;
    logic [CNT_W-1:0] allred_cnt;
    logic [CNT_W-1:0] flash_cnt;
    logic [2:0]       cause;
    mon_state_t       state;

    sig_road_tracker #(.CNT_W(CNT_W), .MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW)) u_hwy (
        .clock(clock), .clear(clear), .code(hwy),
        .bad_trans(h_bad), .short_yellow(h_short), .long_yellow(h_long), .to_green(h_green)
    );

    sig_road_tracker #(.CNT_W(CNT_W), .MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW)) u_cntry (
        .clock(clock), .clear(clear), .code(cntry),
        .bad_trans(c_bad), .short_yellow(c_short), .long_yellow(c_long), .to_green(c_green)
    );

    // History-based checks wait for MON_RUN so the first sample after clear seeds the trackers.
    always_comb begin
        cause = FLT_NONE;
        if (hwy == CODE_BAD || cntry == CODE_BAD)
            cause = FLT_ILLEGAL;
        else if (hwy != RED && cntry != RED)
            cause = FLT_CONFLICT;
        else if (state == MON_RUN) begin
            if (h_bad || c_bad)
                cause = FLT_BAD_TRANS;
            else if (h_short || c_short)
                cause = FLT_SHORT_YELLOW;
            else if (h_long || c_long)
                cause = FLT_LONG_YELLOW;
            else if ((h_green || c_green) && allred_cnt < CNT_W'(MIN_ALLRED))
                cause = FLT_SHORT_ALLRED;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state      <= MON_INIT;
            hwy_lamp   <= RED;
            cntry_lamp <= RED;
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
            allred_cnt <= CNT_W'(MIN_ALLRED);
            flash_cnt  <= '0;
        end else begin
            if (hwy != RED || cntry != RED)
                allred_cnt <= '0;
            else if (allred_cnt != CNT_MAX)
                allred_cnt <= allred_cnt + 1'b1;

            case (state)
                MON_INIT, MON_RUN: begin
                    if (cause != FLT_NONE) begin
                        state      <= MON_FAULT;
                        fault      <= 1'b1;
                        fault_code <= cause;
                        hwy_lamp   <= RED;
                        cntry_lamp <= RED;
                        flash_cnt  <= '0;
                    end else begin
                        state      <= MON_RUN;
                        hwy_lamp   <= hwy;
                        cntry_lamp <= cntry;
                    end
                end
                MON_FAULT: begin
                    if (flash_cnt == CNT_W'(FLASH_DIV - 1)) begin
                        flash_cnt  <= '0;
                        hwy_lamp   <= (hwy_lamp == RED) ? DARK : RED;
                        cntry_lamp <= (hwy_lamp == RED) ? DARK : RED;
                    end else begin
                        flash_cnt  <= flash_cnt + 1'b1;
                    end
                end
                default: state <= MON_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sig_monitor.sv
// Testbench for sig_monitor: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a history-based reference model.
module tb_sig_monitor;

    localparam int MIN_YELLOW = 3;
    localparam int MAX_YELLOW = 8;
    localparam int MIN_ALLRED = 2;
    localparam int FLASH_DIV  = 4;
    localparam int TIMER_MAX  = 15;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic [1:0] hwy   = 2'd0;
    logic [1:0] cntry = 2'd0;
    logic [1:0] hwy_lamp, cntry_lamp;
    logic       fault;
    logic [2:0] fault_code;

    int tests = 0;
    int fails = 0;

    sig_monitor #(
        .CNT_W(4), .MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW),
        .MIN_ALLRED(MIN_ALLRED), .FLASH_DIV(FLASH_DIV)
    ) dut (
        .clock(clock), .clear(clear), .hwy(hwy), .cntry(cntry),
        .hwy_lamp(hwy_lamp), .cntry_lamp(cntry_lamp),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clock = ~clock;

    // Reference model: samples accepted since the last clear, plus the fault record.
    logic [1:0] hq[$];
    logic [1:0] cq[$];
    bit         m_valid = 0;
    bit         m_fault = 0;
    int         m_code  = 0;
    int         m_age   = 0;
    int         m_hl    = 0;
    int         m_cl    = 0;

    function automatic logic [1:0] next_colour(input logic [1:0] c);
        case (c)
            2'd2:    return 2'd1;
            2'd1:    return 2'd0;
            2'd0:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic int trail_yellow(input bit road);
        int  n;
        bit  stop;
        n = 0;
        stop = 0;
        for (int i = hq.size() - 1; i >= 0; i--) begin
            if (!stop) begin
                if ((road ? cq[i] : hq[i]) == 2'd1) n++;
                else stop = 1;
            end
        end
        return (n > TIMER_MAX) ? TIMER_MAX : n;
    endfunction

    function automatic int trail_allred();
        int  n;
        bit  stop;
        n = 0;
        stop = 0;
        for (int i = hq.size() - 1; i >= 0; i--) begin
            if (!stop) begin
                if (hq[i] == 2'd0 && cq[i] == 2'd0) n++;
                else stop = 1;
            end
        end
        if (!stop) n += MIN_ALLRED;
        return (n > TIMER_MAX) ? TIMER_MAX : n;
    endfunction

    function automatic int expect_cause(input logic [1:0] h, input logic [1:0] c);
        logic [1:0] ph, pc;
        if (h == 2'd3 || c == 2'd3) return 1;
        if (h != 2'd0 && c != 2'd0) return 2;
        if (hq.size() == 0) return 0;
        ph = hq[hq.size() - 1];
        pc = cq[cq.size() - 1];
        if ((h != ph && h != next_colour(ph)) || (c != pc && c != next_colour(pc))) return 3;
        if ((ph == 2'd1 && h == 2'd0 && trail_yellow(0) < MIN_YELLOW) ||
            (pc == 2'd1 && c == 2'd0 && trail_yellow(1) < MIN_YELLOW)) return 4;
        if ((h == 2'd1 && trail_yellow(0) >= MAX_YELLOW) ||
            (c == 2'd1 && trail_yellow(1) >= MAX_YELLOW)) return 5;
        if (((ph == 2'd0 && h == 2'd2) || (pc == 2'd0 && c == 2'd2)) &&
            trail_allred() < MIN_ALLRED) return 6;
        return 0;
    endfunction

    initial forever begin
        int k;
        @(posedge clock);
        if (clear) begin
            m_valid = 1; m_fault = 0; m_code = 0; m_age = 0; m_hl = 0; m_cl = 0;
            hq.delete();
            cq.delete();
        end else if (m_valid) begin
            if (m_fault) begin
                m_age++;
                m_hl = ((m_age / FLASH_DIV) % 2 == 1) ? 3 : 0;
                m_cl = m_hl;
            end else begin
                k = expect_cause(hwy, cntry);
                if (k != 0) begin
                    m_fault = 1; m_code = k; m_age = 0; m_hl = 0; m_cl = 0;
                end else begin
                    m_hl = hwy;
                    m_cl = cntry;
                    hq.push_back(hwy);
                    cq.push_back(cntry);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clock);
        if (m_valid) begin
            chk("cyc_hwy_lamp",   32'(hwy_lamp),   32'(m_hl));
            chk("cyc_cntry_lamp", 32'(cntry_lamp), 32'(m_cl));
            chk("cyc_fault",      32'(fault),      32'(m_fault));
            chk("cyc_fault_code", 32'(fault_code), 32'(m_code));
        end
    end

    // Hand-computed expectations: checked against both the DUT and the model.
    task automatic check_lit(input string name, input int f, input int code, input int hl, input int cl);
        chk({name, "_fault"},      32'(fault),      32'(f));
        chk({name, "_code"},       32'(fault_code), 32'(code));
        chk({name, "_hwy_lamp"},   32'(hwy_lamp),   32'(hl));
        chk({name, "_cntry_lamp"}, 32'(cntry_lamp), 32'(cl));
        chk({name, "_model_fault"}, 32'(m_fault), 32'(f));
        chk({name, "_model_code"},  32'(m_code),  32'(code));
        chk({name, "_model_hl"},    32'(m_hl),    32'(hl));
        chk({name, "_model_cl"},    32'(m_cl),    32'(cl));
    endtask

    task automatic cyc(input logic [1:0] h, input logic [1:0] c, input logic clr);
        hwy = h;
        cntry = c;
        clear = clr;
        @(negedge clock);
    endtask

    task automatic run(input logic [1:0] h, input logic [1:0] c, input int n);
        for (int i = 0; i < n; i++) cyc(h, c, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] gh, gc;
        bit         clr;

        // Legal cycle
        cyc(2'd0, 2'd0, 1'b1);
        cyc(2'd0, 2'd0, 1'b1);
        check_lit("reset", 0, 0, 0, 0);
        run(2'd2, 2'd0, 5);
        check_lit("hwy_green", 0, 0, 2, 0);
        run(2'd1, 2'd0, 3);
        run(2'd0, 2'd0, 2);
        run(2'd0, 2'd2, 4);
        check_lit("cntry_green", 0, 0, 0, 2);
        run(2'd0, 2'd1, 3);
        run(2'd0, 2'd0, 2);
        run(2'd2, 2'd0, 1);
        check_lit("legal_cycle", 0, 0, 2, 0);

        // Conflict, then the flash pattern
        run(2'd2, 2'd2, 1);
        check_lit("conflict", 1, 2, 0, 0);
        run(2'd1, 2'd3, 3);
        check_lit("flash_red_last", 1, 2, 0, 0);
        run(2'd2, 2'd2, 1);
        check_lit("flash_dark_first", 1, 2, 3, 3);
        run(2'd0, 2'd1, 3);
        check_lit("flash_dark_last", 1, 2, 3, 3);
        run(2'd0, 2'd0, 1);
        check_lit("flash_red_again", 1, 2, 0, 0);
        run(2'd1, 2'd1, 4);

        // Clear during DARK phase, then INIT takes GREEN as-is
        cyc(2'd1, 2'd1, 1'b1);
        check_lit("clear_mid_fault", 0, 0, 0, 0);
        run(2'd2, 2'd0, 1);
        check_lit("init_green", 0, 0, 2, 0);
        run(2'd2, 2'd0, 2);
        check_lit("green_hold", 0, 0, 2, 0);

        // Skipped yellow
        cyc(2'd0, 2'd0, 1'b1);
        run(2'd2, 2'd0, 2);
        run(2'd0, 2'd0, 1);
        check_lit("skip_yellow", 1, 3, 0, 0);

        // Short yellow
        cyc(2'd0, 2'd0, 1'b1);
        run(2'd2, 2'd0, 1);
        run(2'd1, 2'd0, 2);
        run(2'd0, 2'd0, 1);
        check_lit("short_yellow", 1, 4, 0, 0);

        // Long yellow
        cyc(2'd0, 2'd0, 1'b1);
        run(2'd2, 2'd0, 1);
        run(2'd1, 2'd0, 8);
        check_lit("yellow_8", 0, 0, 1, 0);
        run(2'd1, 2'd0, 1);
        check_lit("long_yellow", 1, 5, 0, 0);

        // Short all-red
        cyc(2'd0, 2'd0, 1'b1);
        run(2'd2, 2'd0, 1);
        run(2'd1, 2'd0, 3);
        run(2'd0, 2'd0, 1);
        check_lit("allred_1", 0, 0, 0, 0);
        run(2'd0, 2'd2, 1);
        check_lit("short_allred", 1, 6, 0, 0);

        // Priority and stickiness
        cyc(2'd0, 2'd0, 1'b1);
        run(2'd0, 2'd0, 1);
        run(2'd3, 2'd2, 1);
        check_lit("priority", 1, 1, 0, 0);
        run(2'd2, 2'd2, 1);
        check_lit("sticky", 1, 1, 0, 0);

        // Randomized traffic with occasional corruption and clears
        cyc(2'd0, 2'd0, 1'b1);
        gh = 2'd0;
        gc = 2'd0;
        for (int n = 0; n < 4000; n++) begin
            clr = 0;
            if (m_fault && $urandom_range(0, 9) == 0) clr = 1;
            else if ($urandom_range(0, 199) == 0) clr = 1;
            if (clr) begin
                gh = 2'd0;
                gc = 2'd0;
            end else begin
                if ($urandom_range(0, 99) < 30 &&
                    !(gh == 2'd0 && gc != 2'd0 && $urandom_range(0, 9) != 0))
                    gh = next_colour(gh);
                if ($urandom_range(0, 99) < 30 &&
                    !(gc == 2'd0 && gh != 2'd0 && $urandom_range(0, 9) != 0))
                    gc = next_colour(gc);
                if ($urandom_range(0, 99) == 0) gh = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 99) == 0) gc = 2'($urandom_range(0, 3));
            end
            cyc(gh, gc, clr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
